// File: rtl/slave_arbiter.sv
`default_nettype none
// ============================================================================
// slave_arbiter : two-port round-robin arbiter/sequencer for one slave memory
// Revision      : 1.0
// ============================================================================
module slave_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_ENTRIES = 256
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  m0_REQ,
   input  logic                  m1_REQ,
   input  logic                  m0_WE,
   input  logic                  m1_WE,
   input  logic [ADDR_WIDTH-1:0] m0_ADDR,
   input  logic [ADDR_WIDTH-1:0] m1_ADDR,
   input  logic [DATA_WIDTH-1:0] m0_WDATA,
   input  logic [DATA_WIDTH-1:0] m1_WDATA,
   output logic                  m0_ACK,
   output logic                  m1_ACK,
   output logic [DATA_WIDTH-1:0] m0_RDATA,
   output logic [DATA_WIDTH-1:0] m1_RDATA,
   output logic                  m0_ERR,
   output logic                  m1_ERR,
   output logic                  w_REQ,
   output logic                  r_REQ,
   output logic [ADDR_WIDTH-1:0] w_ADDR,
   output logic [ADDR_WIDTH-1:0] r_ADDR,
   output logic [DATA_WIDTH-1:0] w_DATA,
   output logic                  oDONE,
   input  logic [DATA_WIDTH-1:0] s_RDATA
);

   localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(NUM_ENTRIES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_CAPT  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  win_q, win_d;
   logic                  last_grant_q, last_grant_d;
   logic                  we_q, we_d;
   logic                  err_q, err_d;
   logic                  m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
   logic                  m0_err_q, m0_err_d, m1_err_q, m1_err_d;
   logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
   logic                  w_req_q, w_req_d, r_req_q, r_req_d;
   logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic                  done_q, done_d;

   logic                  sel_port;
   logic                  sel_we;
   logic                  sel_err;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [DATA_WIDTH-1:0] capt_data;

   // On a tie the port that did not win the previous tie is chosen.
   always_comb begin
      sel_port  = m1_REQ && (!m0_REQ || !last_grant_q);
      sel_we    = sel_port ? m1_WE    : m0_WE;
      sel_addr  = sel_port ? m1_ADDR  : m0_ADDR;
      sel_wdata = sel_port ? m1_WDATA : m0_WDATA;
      sel_err   = ({1'b0, sel_addr} >= ADDR_LIMIT);
      capt_data = (we_q || err_q) ? '0 : s_RDATA;
   end

   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      err_d        = err_q;
      m0_ack_d     = 1'b0;
      m1_ack_d     = 1'b0;
      m0_err_d     = 1'b0;
      m1_err_d     = 1'b0;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      w_req_d      = 1'b0;
      r_req_d      = 1'b0;
      w_addr_d     = w_addr_q;
      r_addr_d     = r_addr_q;
      w_data_d     = w_data_q;
      done_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (m0_REQ || m1_REQ) begin
               win_d    = sel_port;
               we_d     = sel_we;
               err_d    = sel_err;
               w_req_d  = sel_we && !sel_err;
               r_req_d  = !sel_we && !sel_err;
               w_addr_d = sel_addr;
               r_addr_d = sel_addr;
               w_data_d = sel_wdata;
               if (m0_REQ && m1_REQ) begin
                  last_grant_d = sel_port;
               end
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_CAPT;
         end
         S_CAPT: begin
            // Slave read data became valid at the previous edge.
            if (win_q) begin
               m1_ack_d   = 1'b1;
               m1_err_d   = err_q;
               m1_rdata_d = capt_data;
            end else begin
               m0_ack_d   = 1'b1;
               m0_err_d   = err_q;
               m0_rdata_d = capt_data;
            end
            done_d  = 1'b1;
            state_d = S_ACK;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q      <= S_IDLE;
         win_q        <= 1'b0;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         m0_ack_q     <= 1'b0;
         m1_ack_q     <= 1'b0;
         m0_err_q     <= 1'b0;
         m1_err_q     <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         w_req_q      <= 1'b0;
         r_req_q      <= 1'b0;
         w_addr_q     <= '0;
         r_addr_q     <= '0;
         w_data_q     <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_q        <= win_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         err_q        <= err_d;
         m0_ack_q     <= m0_ack_d;
         m1_ack_q     <= m1_ack_d;
         m0_err_q     <= m0_err_d;
         m1_err_q     <= m1_err_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
         w_req_q      <= w_req_d;
         r_req_q      <= r_req_d;
         w_addr_q     <= w_addr_d;
         r_addr_q     <= r_addr_d;
         w_data_q     <= w_data_d;
         done_q       <= done_d;
      end
   end

   assign m0_ACK   = m0_ack_q;
   assign m1_ACK   = m1_ack_q;
   assign m0_ERR   = m0_err_q;
   assign m1_ERR   = m1_err_q;
   assign m0_RDATA = m0_rdata_q;
   assign m1_RDATA = m1_rdata_q;
   assign w_REQ    = w_req_q;
   assign r_REQ    = r_req_q;
   assign w_ADDR   = w_addr_q;
   assign r_ADDR   = r_addr_q;
   assign w_DATA   = w_data_q;
   assign oDONE    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_slave_arbiter.sv
`default_nettype none
// ============================================================================
// tb_slave_arbiter : randomized and directed bench for slave_arbiter
// Revision         : 1.0
// ============================================================================
module tb_slave_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NE = 256;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   logic          iCLK = 1'b0;
   logic          iRST = 1'b0;
   logic          m0_REQ = 1'b0, m1_REQ = 1'b0, m0_WE = 1'b0, m1_WE = 1'b0;
   logic [AW-1:0] m0_ADDR = '0, m1_ADDR = '0;
   logic [DW-1:0] m0_WDATA = '0, m1_WDATA = '0;
   logic          m0_ACK, m1_ACK, m0_ERR, m1_ERR;
   logic [DW-1:0] m0_RDATA, m1_RDATA;
   logic          w_REQ, r_REQ, oDONE;
   logic [AW-1:0] w_ADDR, r_ADDR;
   logic [DW-1:0] w_DATA;
   logic [DW-1:0] s_RDATA = '0;

   always #5 iCLK = ~iCLK;

   slave_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENTRIES(NE)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .m0_REQ(m0_REQ), .m1_REQ(m1_REQ), .m0_WE(m0_WE), .m1_WE(m1_WE),
      .m0_ADDR(m0_ADDR), .m1_ADDR(m1_ADDR), .m0_WDATA(m0_WDATA), .m1_WDATA(m1_WDATA),
      .m0_ACK(m0_ACK), .m1_ACK(m1_ACK), .m0_RDATA(m0_RDATA), .m1_RDATA(m1_RDATA),
      .m0_ERR(m0_ERR), .m1_ERR(m1_ERR), .w_REQ(w_REQ), .r_REQ(r_REQ),
      .w_ADDR(w_ADDR), .r_ADDR(r_ADDR), .w_DATA(w_DATA), .oDONE(oDONE),
      .s_RDATA(s_RDATA)
   );

   // Slave memory with registered read data
   logic [DW-1:0] smem [NE];
   initial for (int i = 0; i < NE; i++) smem[i] = '0;
   always @(posedge iCLK) begin
      if (w_REQ && w_ADDR < 32'(NE)) smem[w_ADDR[7:0]] <= w_DATA;
      if (r_REQ) s_RDATA <= (r_ADDR < 32'(NE)) ? smem[r_ADDR[7:0]] : '0;
   end

   int n_checks = 0;
   int n_pass   = 0;
   int k        = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, k);
   endtask

   // Requesters
   txn_t q0[$], q1[$];
   txn_t mtx [2];
   bit   mact [2];
   bit   ack_seen [2];

   // Transaction-level reference model
   logic [DW-1:0] rmem [NE];
   int            next_sample = 0;
   bit            last_grant  = 1'b1;
   bit            cur_valid   = 1'b0;
   int            cur_port    = 0;
   int            cur_edge    = 0;
   txn_t          cur_tx;
   bit            cur_err;
   logic [DW-1:0] cur_rdata;
   int            grant_log[$];
   int            ack_log[$];
   logic [DW-1:0] last_rdata [2];
   bit            last_err [2];
   int            ack_k [2];

   task automatic model_edge();
      int p;
      k++;
      if (iRST && k >= next_sample && (mact[0] || mact[1])) begin
         if (mact[0] && mact[1]) begin
            p = last_grant ? 0 : 1;
            last_grant = (p == 1);
         end else begin
            p = mact[1] ? 1 : 0;
         end
         cur_valid   = 1'b1;
         cur_port    = p;
         cur_tx      = mtx[p];
         cur_edge    = k;
         next_sample = k + 4;
         cur_err     = (cur_tx.addr >= 32'(NE));
         cur_rdata   = '0;
         if (!cur_err) begin
            if (cur_tx.we) rmem[cur_tx.addr[7:0]] = cur_tx.wdata;
            else           cur_rdata = rmem[cur_tx.addr[7:0]];
         end
         grant_log.push_back(p);
      end
   endtask

   task automatic drive_masters();
      for (int p = 0; p < 2; p++) begin
         if (mact[p] && ack_seen[p]) mact[p] = 1'b0;
         ack_seen[p] = 1'b0;
         if (!mact[p]) begin
            if (p == 0 && q0.size() > 0) begin mtx[0] = q0.pop_front(); mact[0] = 1'b1; end
            if (p == 1 && q1.size() > 0) begin mtx[1] = q1.pop_front(); mact[1] = 1'b1; end
         end
      end
      m0_REQ = mact[0]; m0_WE = mtx[0].we; m0_ADDR = mtx[0].addr; m0_WDATA = mtx[0].wdata;
      m1_REQ = mact[1]; m1_WE = mtx[1].we; m1_ADDR = mtx[1].addr; m1_WDATA = mtx[1].wdata;
   endtask

   task automatic check_outputs();
      int ph;
      bit e_done, e_ack0, e_ack1, e_w, e_r;
      ph     = cur_valid ? (k - cur_edge) : -1;
      e_done = (ph == 2);
      e_ack0 = e_done && cur_port == 0;
      e_ack1 = e_done && cur_port == 1;
      e_w    = (ph == 0) && cur_tx.we && !cur_err;
      e_r    = (ph == 0) && !cur_tx.we && !cur_err;
      check("m0_ACK", m0_ACK, e_ack0);
      check("m1_ACK", m1_ACK, e_ack1);
      check("w_REQ", w_REQ, e_w);
      check("r_REQ", r_REQ, e_r);
      check("oDONE", oDONE, e_done);
      if (e_w) begin
         check("w_ADDR", w_ADDR, cur_tx.addr);
         check("w_DATA", w_DATA, cur_tx.wdata);
      end
      if (e_r) check("r_ADDR", r_ADDR, cur_tx.addr);
      if (e_ack0) begin
         check("m0_RDATA", m0_RDATA, cur_rdata);
         check("m0_ERR", m0_ERR, cur_err);
      end
      if (e_ack1) begin
         check("m1_RDATA", m1_RDATA, cur_rdata);
         check("m1_ERR", m1_ERR, cur_err);
      end
      if (m0_ACK) begin
         ack_seen[0] = 1'b1; ack_k[0] = k; last_rdata[0] = m0_RDATA; last_err[0] = m0_ERR;
         ack_log.push_back(k);
      end
      if (m1_ACK) begin
         ack_seen[1] = 1'b1; ack_k[1] = k; last_rdata[1] = m1_RDATA; last_err[1] = m1_ERR;
         ack_log.push_back(k);
      end
   endtask

   task automatic step();
      @(posedge iCLK);
      model_edge();
      #1;
      drive_masters();
      @(negedge iCLK);
      check_outputs();
   endtask

   task automatic run_idle(input int budget);
      int n = 0;
      while ((mact[0] || mact[1] || q0.size() > 0 || q1.size() > 0) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) check("timeout", 1, 0);
      repeat (2) step();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"}, {m0_ACK, m1_ACK, m0_ERR, m1_ERR, w_REQ, r_REQ, oDONE}, 0);
      check({tag, "_rdata"}, {m0_RDATA, m1_RDATA}, 0);
      check({tag, "_addr"}, {w_ADDR, r_ADDR}, 0);
      check({tag, "_wdata"}, w_DATA, 0);
   endtask

   function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      t.we = we; t.addr = a; t.wdata = d;
      return t;
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      t.we    = 1'($urandom_range(0, 1));
      t.wdata = $urandom;
      case ($urandom_range(0, 9))
         0:       t.addr = 32'(NE + $urandom_range(0, 255));
         1:       t.addr = $urandom;
         default: t.addr = 32'($urandom_range(0, 15));
      endcase
      return t;
   endfunction

   initial begin
      int base, n;
      for (int i = 0; i < NE; i++) rmem[i] = '0;
      mtx[0] = mk(0, 0, 0); mtx[1] = mk(0, 0, 0);
      mact[0] = 0; mact[1] = 0; ack_seen[0] = 0; ack_seen[1] = 0;

      // Reset state
      repeat (2) step();
      check_all_zero("reset");
      iRST = 1'b1;
      step();

      // Write then read back on port 0
      q0.push_back(mk(1, 32'h10, 32'hDEADBEEF));
      q0.push_back(mk(0, 32'h10, 32'h0));
      run_idle(40);
      check("t1_rdata", last_rdata[0], 32'hDEADBEEF);
      check("t1_err", last_err[0], 0);

      // Simultaneous requests, reset tie-break favours port 0
      base = grant_log.size();
      q0.push_back(mk(1, 32'h20, 32'h11111111));
      q1.push_back(mk(0, 32'h20, 32'h0));
      run_idle(40);
      check("t2_first", grant_log[base], 0);
      check("t2_gap", 64'(ack_k[1] - ack_k[0]), 4);
      check("t2_rdata", last_rdata[1], 32'h11111111);

      // Continuous dual requests: strict alternation, 4-cycle spacing
      base = grant_log.size();
      n    = ack_log.size();
      for (int i = 0; i < 4; i++) begin
         q0.push_back(rand_txn());
         q1.push_back(rand_txn());
      end
      run_idle(100);
      check("t3_count", grant_log.size() - base, 8);
      for (int i = base + 1; i < grant_log.size(); i++)
         check("t3_alt", grant_log[i] != grant_log[i-1], 1);
      for (int i = n + 1; i < ack_log.size(); i++)
         check("t3_space", 64'(ack_log[i] - ack_log[i-1]), 4);

      // Out-of-range read on port 1
      q1.push_back(mk(0, 32'h100, 32'h0));
      run_idle(40);
      check("t4_err", last_err[1], 1);
      check("t4_rdata", last_rdata[1], 0);

      // Reset during CAPT of a read
      q0.push_back(mk(1, 32'h30, 32'hA5A5A5A5));
      run_idle(40);
      q0.push_back(mk(0, 32'h30, 32'h0));
      n = 0;
      while (!(cur_valid && cur_tx.addr == 32'h30 && !cur_tx.we && k - cur_edge == 1) && n < 20) begin
         step();
         n++;
      end
      check("t5_reach_capt", n < 20, 1);
      iRST = 1'b0;
      #1;
      check_all_zero("t5_abort");
      cur_valid = 1'b0; last_grant = 1'b1; next_sample = 0;
      mact[0] = 0; mact[1] = 0; ack_seen[0] = 0; ack_seen[1] = 0;
      q0.delete(); q1.delete();
      repeat (2) step();
      iRST = 1'b1;
      base = grant_log.size();
      q0.push_back(mk(0, 32'h30, 32'h0));
      q1.push_back(mk(0, 32'h30, 32'h0));
      run_idle(40);
      check("t5_tie", grant_log[base], 0);
      check("t5_rd0", last_rdata[0], 32'hA5A5A5A5);
      check("t5_rd1", last_rdata[1], 32'hA5A5A5A5);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         if (q0.size() == 0 && $urandom_range(0, 3) == 0) q0.push_back(rand_txn());
         if (q1.size() == 0 && $urandom_range(0, 3) == 0) q1.push_back(rand_txn());
         step();
      end
      run_idle(60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
